// File: rtl/mmu_req_arb.sv
// mmu_req_arb
// Round-robin request front-end for mmu_top. N_CH pipeline/DMA clients post
// read or write requests. One transaction at a time is issued on mmu_top's
// rd_*/wr_* ports, and the rd_valid/wr_done response is returned to the
// channel that owns the transaction. Lives entirely in the mmu_clk domain.
//
// Ports
//   mmu_clk, i_rst       clock, synchronous active-high reset
//   ch_req, ch_we        per-channel request level (held until ch_ack) and
//                        direction (1 = write)
//   ch_addr, ch_wdata,   packed per-channel fields; channel i sits at
//   ch_func3, ch_reg     [i*W +: W] for the field width W
//   ch_ack, ch_err       one-cycle completion / error pulse to the owner
//   ch_rdata             read data, valid while any ch_ack bit is high
//   busy                 high while a transaction is in flight
//   rd_req, wr_req       one-cycle issue pulses to mmu_top
//   rd_addr, wr_addr,    issued fields, stable from the issue cycle until the
//   wr_data, rd_req_func3,  return to IDLE; the unused direction's fields
//   wr_req_func3, rd_req_reg  are held at 0
//   rd_valid, rd_data    read response from mmu_top
//   wr_done              write completion from mmu_top
//
// Build option
//   MMU_ARB_TIMEOUT_EN   when defined, a WAIT lasting TIMEOUT cycles without a
//                        response completes with ch_ack and ch_err set and
//                        ch_rdata = 0. When undefined, WAIT persists until a
//                        response arrives and ch_err is constant 0.
//
// State | meaning
// IDLE  | nothing in flight; arbitrate among requesting channels
// ISSUE | single-cycle rd_req or wr_req pulse to mmu_top
// WAIT  | waiting for the response that matches the issued direction
// DONE  | single-cycle ch_ack (and ch_err) to the owning channel

module mmu_req_arb #(
    parameter int N_CH    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                     mmu_clk,
    input  logic                     i_rst,

    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH-1:0]          ch_we,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_wdata,
    input  logic [N_CH*3-1:0]        ch_func3,
    input  logic [N_CH*5-1:0]        ch_reg,
    output logic [N_CH-1:0]          ch_ack,
    output logic [N_CH-1:0]          ch_err,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     busy,

    output logic                     rd_req,
    output logic                     wr_req,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [2:0]               rd_req_func3,
    output logic [2:0]               wr_req_func3,
    output logic [4:0]               rd_req_reg,
    input  logic                     rd_valid,
    input  logic [DATA_W-1:0]        rd_data,
    input  logic                     wr_done
);

    localparam int G_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [G_W-1:0]      r_rr;
    logic [G_W-1:0]      r_g;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_func3;
    logic [4:0]          r_reg;
    logic [DATA_W-1:0]   r_rdata;

    logic [2*N_CH-1:0]   w_rot;
    logic                w_any;
    logic [G_W-1:0]      w_gnt;
    logic [G_W-1:0]      w_rr_nxt;
    logic                w_resp;
    logic                w_timeout;
    logic                w_busy;
    logic                w_done;
    logic [N_CH-1:0]     w_onehot;

    // Rotating the doubled request vector by rr_ptr puts the highest-priority
    // channel at bit 0; the lowest set bit of the low half is the winner.
    // Iterating downwards lets the lowest set bit overwrite the others.
    always_comb begin
        int v_idx;
        w_rot = {ch_req, ch_req} >> r_rr;
        w_any = 1'b0;
        w_gnt = '0;
        v_idx = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                v_idx = int'(r_rr) + i;
                if (v_idx >= N_CH) begin
                    v_idx = v_idx - N_CH;
                end
                w_any = 1'b1;
                w_gnt = G_W'(v_idx);
            end
        end
    end

    assign w_rr_nxt = (w_gnt == G_W'(N_CH - 1)) ? '0 : w_gnt + 1'b1;

    // Only the response matching the issued direction ends WAIT.
    assign w_resp = (r_state == S_WAIT) && (r_we ? wr_done : rd_valid);

    always_ff @(posedge mmu_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_g     <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_func3 <= '0;
            r_reg   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_ISSUE;
                        r_g     <= w_gnt;
                        r_rr    <= w_rr_nxt;
                        r_we    <= ch_we[w_gnt];
                        r_addr  <= ch_addr[int'(w_gnt) * ADDR_W +: ADDR_W];
                        r_wdata <= ch_wdata[int'(w_gnt) * DATA_W +: DATA_W];
                        r_func3 <= ch_func3[int'(w_gnt) * 3 +: 3];
                        r_reg   <= ch_reg[int'(w_gnt) * 5 +: 5];
                        r_rdata <= '0;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A response in the same cycle as the limit takes priority.
                    if (w_resp) begin
                        r_state <= S_DONE;
                        r_rdata <= r_we ? '0 : rd_data;
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                        r_rdata <= '0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MMU_ARB_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    // Counter is zero on the first WAIT cycle, so the limit is hit in the
    // TIMEOUT-th WAIT cycle and DONE follows TIMEOUT cycles after WAIT entry.
    always_ff @(posedge mmu_clk) begin
        if (i_rst) begin
            r_to_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge mmu_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_err <= 1'b0;
        end else if (r_state == S_WAIT && !w_resp && w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign ch_err = ch_ack & {N_CH{r_err}};
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_timeout        = 1'b0;
    assign ch_err           = '0;
`endif

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_onehot[i] = (r_g == G_W'(i));
        end
    end

    assign w_busy = (r_state != S_IDLE);
    assign w_done = (r_state == S_DONE);

    assign busy         = w_busy;
    assign ch_ack       = w_done ? w_onehot : '0;
    assign ch_rdata     = w_done ? r_rdata : '0;

    assign rd_req       = (r_state == S_ISSUE) && !r_we;
    assign wr_req       = (r_state == S_ISSUE) &&  r_we;
    assign rd_addr      = (w_busy && !r_we) ? r_addr  : '0;
    assign rd_req_func3 = (w_busy && !r_we) ? r_func3 : '0;
    assign rd_req_reg   = (w_busy && !r_we) ? r_reg   : '0;
    assign wr_addr      = (w_busy &&  r_we) ? r_addr  : '0;
    assign wr_data      = (w_busy &&  r_we) ? r_wdata : '0;
    assign wr_req_func3 = (w_busy &&  r_we) ? r_func3 : '0;

endmodule

// File: tb/tb_mmu_req_arb.sv
// Bench for mmu_req_arb: directed scenarios with literal expectations, then
// randomized clients/responder checked every cycle against a timestamp-based
// transaction model (grant cycle, response cycle, ack = response + 1).

module tb_mmu_req_arb;

    localparam int N_CH    = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;
`ifdef MMU_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                   mmu_clk = 1'b0;
    logic                   i_rst;
    logic [N_CH-1:0]        ch_req, ch_we;
    logic [N_CH*ADDR_W-1:0] ch_addr;
    logic [N_CH*DATA_W-1:0] ch_wdata;
    logic [N_CH*3-1:0]      ch_func3;
    logic [N_CH*5-1:0]      ch_reg;
    logic [N_CH-1:0]        ch_ack, ch_err;
    logic [DATA_W-1:0]      ch_rdata;
    logic                   busy, rd_req, wr_req;
    logic [ADDR_W-1:0]      rd_addr, wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic [2:0]             rd_req_func3, wr_req_func3;
    logic [4:0]             rd_req_reg;
    logic                   rd_valid, wr_done;
    logic [DATA_W-1:0]      rd_data;

    always #5 mmu_clk = ~mmu_clk;

    mmu_req_arb #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .mmu_clk(mmu_clk), .i_rst(i_rst),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_func3(ch_func3), .ch_reg(ch_reg),
        .ch_ack(ch_ack), .ch_err(ch_err), .ch_rdata(ch_rdata), .busy(busy),
        .rd_req(rd_req), .wr_req(wr_req), .rd_addr(rd_addr), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_req_func3(rd_req_func3), .wr_req_func3(wr_req_func3),
        .rd_req_reg(rd_req_reg), .rd_valid(rd_valid), .rd_data(rd_data), .wr_done(wr_done)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // transaction model
    bit                m_act   = 1'b0;
    int                m_tg    = 0;
    int                m_tr    = -1;
    int                m_g     = 0;
    int                m_rr    = 0;
    bit                m_we    = 1'b0;
    bit                m_err   = 1'b0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [2:0]        m_func3 = '0;
    logic [4:0]        m_reg   = '0;
    logic [DATA_W-1:0] m_rdata = '0;

    // stimulus controls
    bit resp_auto = 1'b0, cli_auto = 1'b0, spur = 1'b0;
    int lat_max = 0, cli_prob = 0;
    bit pend_on = 1'b0, pend_rd = 1'b0;
    int pend = 0;
    int ack_idx_q[$];
    int ack_cyc_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit is_ack, is_iss;
        logic [N_CH-1:0] e_ack;
        is_ack = m_act && (m_tr >= 0) && (cyc == m_tr + 1);
        is_iss = m_act && (cyc == m_tg + 1);
        e_ack  = is_ack ? (N_CH'(1) << m_g) : '0;
        if (chk_en) begin
            chk("busy",         busy,         m_act);
            chk("rd_req",       rd_req,       is_iss && !m_we);
            chk("wr_req",       wr_req,       is_iss && m_we);
            chk("rd_addr",      rd_addr,      (m_act && !m_we) ? m_addr  : '0);
            chk("rd_req_func3", rd_req_func3, (m_act && !m_we) ? m_func3 : '0);
            chk("rd_req_reg",   rd_req_reg,   (m_act && !m_we) ? m_reg   : '0);
            chk("wr_addr",      wr_addr,      (m_act && m_we) ? m_addr  : '0);
            chk("wr_data",      wr_data,      (m_act && m_we) ? m_wdata : '0);
            chk("wr_req_func3", wr_req_func3, (m_act && m_we) ? m_func3 : '0);
            chk("ch_ack",       ch_ack,       e_ack);
            chk("ch_err",       ch_err,       m_err ? e_ack : '0);
            chk("ch_rdata",     ch_rdata,     is_ack ? m_rdata : '0);
        end
        if (i_rst) begin
            m_act = 1'b0;
            m_rr  = 0;
        end else if (!m_act) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (ch_req[(m_rr + i) % N_CH]) m_g = (m_rr + i) % N_CH;
            end
            if (ch_req != '0) begin
                m_act   = 1'b1;
                m_tg    = cyc;
                m_tr    = -1;
                m_err   = 1'b0;
                m_rr    = (m_g + 1) % N_CH;
                m_we    = ch_we[m_g];
                m_addr  = ch_addr[m_g*ADDR_W +: ADDR_W];
                m_wdata = ch_wdata[m_g*DATA_W +: DATA_W];
                m_func3 = ch_func3[m_g*3 +: 3];
                m_reg   = ch_reg[m_g*5 +: 5];
            end
        end else if (is_ack) begin
            m_act = 1'b0;
        end else if (m_tr < 0 && cyc >= m_tg + 2) begin
            if (m_we ? wr_done : rd_valid) begin
                m_tr    = cyc;
                m_rdata = m_we ? '0 : rd_data;
            end else if (TO_EN && (cyc - (m_tg + 2) == TIMEOUT - 1)) begin
                m_tr    = cyc;
                m_err   = 1'b1;
                m_rdata = '0;
            end
        end
    endtask

    // One clock cycle: check/update at the falling edge, then drive the next
    // cycle's inputs 1 time unit after the rising edge.
    task automatic step();
        logic [N_CH-1:0] acked;
        bit iss, iss_rd;
        @(negedge mmu_clk);
        cyc++;
        model_step();
        acked  = ch_ack;
        iss    = rd_req | wr_req;
        iss_rd = rd_req;
        if (ch_ack != '0) begin
            for (int i = 0; i < N_CH; i++) if (ch_ack[i]) ack_idx_q.push_back(i);
            ack_cyc_q.push_back(cyc);
        end
        @(posedge mmu_clk);
        #1;
        if (resp_auto) begin
            rd_valid = 1'b0;
            wr_done  = 1'b0;
            rd_data  = $urandom;
            if (iss) begin
                pend_on = 1'b1;
                pend    = $urandom_range(0, lat_max);
                pend_rd = iss_rd;
            end
            if (pend_on && pend == 0) begin
                pend_on = 1'b0;
                if (pend_rd) rd_valid = 1'b1;
                else         wr_done  = 1'b1;
            end else begin
                if (pend_on) pend--;
                if (spur && $urandom_range(0, 7) == 0) begin
                    if ($urandom_range(0, 1) == 1) rd_valid = 1'b1;
                    else                           wr_done  = 1'b1;
                end
            end
        end
        if (cli_auto) begin
            for (int i = 0; i < N_CH; i++) begin
                if (acked[i]) ch_req[i] = 1'b0;
                else if (!ch_req[i] && $urandom_range(0, 99) < cli_prob) ch_req[i] = 1'b1;
                ch_we[i]                     = 1'($urandom_range(0, 1));
                ch_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom);
                ch_wdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                ch_func3[i*3 +: 3]           = 3'($urandom);
                ch_reg[i*5 +: 5]             = 5'($urandom);
            end
        end
    endtask

    initial begin
        int rr_exp[5];
        rr_exp = '{0, 1, 2, 3, 0};
        i_rst = 1'b1; ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
        ch_func3 = '0; ch_reg = '0; rd_valid = 1'b0; rd_data = '0; wr_done = 1'b0;
        @(posedge mmu_clk);
        #1;
        chk_en = 1'b1;
        repeat (3) step();
        chk("reset_busy", busy, 0);
        chk("reset_ack", ch_ack, 0);
        chk("reset_req", {rd_req, wr_req}, 0);
        i_rst = 1'b0;

        // single read on channel 2, response 2 cycles after rd_req
        ch_req = 4'b0100; ch_we = '0;
        ch_addr[2*ADDR_W +: ADDR_W] = 32'h0000_000A;
        ch_reg[2*5 +: 5] = 5'd5;
        ch_func3[2*3 +: 3] = 3'd2;
        step();
        chk("rd1_req", rd_req, 1);
        chk("rd1_addr", rd_addr, 32'hA);
        chk("rd1_reg", rd_req_reg, 5);
        step();
        step();
        rd_valid = 1'b1; rd_data = 32'hDEADBEEF;
        step();
        rd_valid = 1'b0;
        chk("rd1_ack", ch_ack, 4'b0100);
        chk("rd1_rdata", ch_rdata, 32'hDEADBEEF);
        ch_req = '0;
        step();
        chk("rd1_idle", busy, 0);

        // write on channel 1, wr_done during ISSUE ignored
        ch_req = 4'b0010; ch_we = 4'b0010;
        ch_addr[1*ADDR_W +: ADDR_W] = 32'h100;
        ch_wdata[1*DATA_W +: DATA_W] = 32'h1234;
        step();
        chk("wr_req", wr_req, 1);
        chk("wr_no_rd", rd_req, 0);
        chk("wr_addr", wr_addr, 32'h100);
        chk("wr_data", wr_data, 32'h1234);
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        step();
        chk("wr_issue_done_ignored", {busy, ch_ack}, {1'b1, 4'b0000});
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        chk("wr_ack", ch_ack, 4'b0010);
        chk("wr_rdata0", ch_rdata, 0);
        ch_req = '0; ch_we = '0;
        step();

        // spurious rd_valid in IDLE, cross wr_done during a read WAIT
        rd_valid = 1'b1;
        step();
        rd_valid = 1'b0;
        chk("spur_idle", {busy, ch_ack}, 0);
        ch_req = 4'b0001;
        ch_addr[0 +: ADDR_W] = 32'h44;
        step();
        step();
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        chk("cross_ignored", {busy, ch_ack}, {1'b1, 4'b0000});
        rd_valid = 1'b1; rd_data = 32'h5555AAAA;
        step();
        rd_valid = 1'b0;
        chk("cross_ack", ch_ack, 4'b0001);
        chk("cross_rdata", ch_rdata, 32'h5555AAAA);
        ch_req = '0;
        step();

        // no response: timeout (option) or persistent WAIT
        ch_req = 4'b1000;
        ch_addr[3*ADDR_W +: ADDR_W] = 32'h77;
        step();
        chk("to_issue", rd_req, 1);
        for (int j = 0; j < 8; j++) begin
            step();
            chk("to_no_early_ack", ch_ack, 0);
        end
        step();
        if (TO_EN) begin
            chk("to_ack", ch_ack, 4'b1000);
            chk("to_err", ch_err, 4'b1000);
            chk("to_rdata", ch_rdata, 0);
            ch_req = '0;
            step();
        end else begin
            chk("wait_persists", {busy, ch_ack}, {1'b1, 4'b0000});
            repeat (20) step();
            rd_valid = 1'b1; rd_data = 32'h0BAD_F00D;
            step();
            rd_valid = 1'b0;
            chk("late_ack", ch_ack, 4'b1000);
            chk("late_err", ch_err, 0);
            ch_req = '0;
            step();
        end

        // reset during WAIT, late response ignored, ch3 served normally
        ch_req = 4'b0010; ch_we = '0;
        ch_addr[1*ADDR_W +: ADDR_W] = 32'h200;
        step();
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        ch_req = '0;
        rd_valid = 1'b1;
        chk("rst_busy", busy, 0);
        step();
        rd_valid = 1'b0;
        chk("rst_no_ack", {busy, ch_ack}, 0);
        ch_req = 4'b1000;
        ch_addr[3*ADDR_W +: ADDR_W] = 32'h300;
        step();
        chk("rst_ch3_addr", rd_addr, 32'h300);
        step();
        rd_valid = 1'b1;
        step();
        rd_valid = 1'b0;
        chk("rst_ch3_ack", ch_ack, 4'b1000);
        ch_req = '0;
        step();

        // round robin with all channels requesting, zero-latency responses
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        ack_idx_q.delete();
        ack_cyc_q.delete();
        resp_auto = 1'b1; lat_max = 0; spur = 1'b0;
        cli_auto = 1'b1; cli_prob = 100;
        ch_req = 4'b1111;
        repeat (25) step();
        for (int j = 0; j < 5; j++) begin
            chk("rr_order", (j < ack_idx_q.size()) ? ack_idx_q[j] : -1, rr_exp[j]);
            if (j > 0) chk("rr_spacing", (j < ack_cyc_q.size()) ? ack_cyc_q[j] - ack_cyc_q[j-1] : -1, 4);
        end

        // randomized traffic with spurious responses and occasional reset
        lat_max = 3; spur = 1'b1; cli_prob = 30;
        for (int j = 0; j < 3000; j++) begin
            i_rst = ($urandom_range(0, 499) == 0);
            step();
        end
        i_rst = 1'b0;
        cli_auto = 1'b0;
        ch_req = '0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
